// File: rtl/seg_scan_ctrl.sv
// Eight-slot multiplexed scanner for four signed 4-bit values (magnitude + sign digit each).
// Optional SEG_SCAN_DP_EN lights the DP on the magnitude digit of the most recently written value.
module seg_scan_ctrl #(
  parameter int DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blank,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_idx,
  input  logic [3:0]  wr_data,
  output logic [3:0]  conv_in,
  input  logic [15:0] conv_out,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  localparam logic [15:0] CNT_LAST = 16'(DIV - 2);

  state_t          state, state_nxt;
  logic [2:0]      slot, slot_nxt;
  logic [15:0]     cnt, cnt_nxt;
  logic [3:0][3:0] val;
  logic [7:0]      seg_nxt, an_nxt, half;
  logic            wr_fire, dp_lit;

  assign wr_fire = wr_valid & wr_ready;
  assign conv_in = val[slot[2:1]];
  assign half    = slot[0] ? conv_out[15:8] : conv_out[7:0];

`ifdef SEG_SCAN_DP_EN
  logic [1:0] last;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       last <= 2'd0;
    else if (wr_fire) last <= wr_idx;

  assign dp_lit = ~slot[0] & (slot[2:1] == last);
`else
  assign dp_lit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       val <= '0;
    else if (wr_fire) val[wr_idx] <= wr_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      slot  <= 3'd0;
      cnt   <= 16'd0;
      seg_o <= 8'hFF;
      an_o  <= 8'hFF;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      cnt   <= cnt_nxt;
      seg_o <= seg_nxt;
      an_o  <= an_nxt;
    end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    cnt_nxt   = cnt;
    seg_nxt   = seg_o;
    an_nxt    = an_o;
    wr_ready  = 1'b1;
    case (state)
      IDLE: state_nxt = LOAD;
      LOAD: begin
        // converter output is sampled here only, so displays never glitch mid-slot
        wr_ready  = 1'b0;
        state_nxt = HOLD;
        seg_nxt   = (half | 8'h01) & ~{7'b0, dp_lit};
        an_nxt    = ~(8'h01 << slot);
        cnt_nxt   = 16'd0;
      end
      HOLD:
        if (cnt == CNT_LAST) begin
          state_nxt = LOAD;
          slot_nxt  = slot + 3'd1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      default: state_nxt = IDLE;
    endcase
    // blank overrides everything but keeps slot so the scan resumes where it stopped
    if (blank) begin
      state_nxt = IDLE;
      slot_nxt  = slot;
      cnt_nxt   = cnt;
      seg_nxt   = 8'hFF;
      an_nxt    = 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIV=4): expected slots queued at stimulus time, popped on each digit change.
module tb_seg_scan_ctrl;
  localparam int DIV = 4;

  logic        clk = 1'b0, rst_n = 1'b0, blank = 1'b1, wr_valid = 1'b0;
  logic [1:0]  wr_idx = 2'd0;
  logic [3:0]  wr_data = 4'd0;
  logic        wr_ready;
  logic [3:0]  conv_in;
  logic [15:0] conv_out;
  logic [7:0]  seg_o, an_o;

  int npass = 0, ntot = 0, acc_cnt = 0, last_w = 0, a0, n;
  logic [3:0] mval [4];

  typedef struct {logic [7:0] an; logic [7:0] seg; int dur;} exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .blank(blank), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_data(wr_data), .conv_in(conv_in), .conv_out(conv_out),
    .seg_o(seg_o), .an_o(an_o)
  );

  // converter stand-in: distinct magnitude patterns, minus sign FC, DP bit driven 0 everywhere
  function automatic logic [7:0] mag_pat(logic [3:0] v);
    logic [3:0] a;
    a = v[3] ? -v : v;
    case (a)
      4'd0: return 8'h02;  4'd1: return 8'h9E;  4'd2: return 8'h24;
      4'd3: return 8'h0C;  4'd4: return 8'h98;  4'd5: return 8'h48;
      4'd6: return 8'h40;  4'd7: return 8'h1E;  default: return 8'h00;
    endcase
  endfunction

  assign conv_out = {conv_in[3] ? 8'hFC : 8'hFE, mag_pat(conv_in)};

  always @(posedge clk) if (rst_n && wr_valid && wr_ready) acc_cnt <= acc_cnt + 1;

  function automatic logic [7:0] exp_seg(int s);
    logic [7:0] p;
    logic [3:0] v;
    v = mval[s / 2];
    p = (s % 2 == 1) ? (v[3] ? 8'hFC : 8'hFE) : mag_pat(v);
    p[0] = 1'b1;
`ifdef SEG_SCAN_DP_EN
    if (s % 2 == 0 && s / 2 == last_w) p[0] = 1'b0;
`endif
    return p;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_slot(int s, int dur);
    exp_t e;
    e.an  = ~(8'h01 << s);
    e.seg = exp_seg(s);
    e.dur = dur;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [7:0] prev;
    int k;
    e = sb.pop_front();
    prev = an_o;
    k = 0;
    do begin @(negedge clk); k++; end while (an_o === prev && k < 64);
    chk("slot_timeout", 32'(k < 64), 32'd1);
    chk("slot_an", 32'(an_o), 32'(e.an));
    chk("slot_seg", 32'(seg_o), 32'(e.seg));
    if (e.dur > 0) chk("slot_len", k, e.dur);
  endtask

  initial begin
    foreach (mval[i]) mval[i] = 4'd0;
    #12;
    chk("rst_an", 32'(an_o), 32'hFF);
    chk("rst_seg", 32'(seg_o), 32'hFF);
    chk("rst_rdy", 32'(wr_ready), 32'd1);
    chk("rst_conv", 32'(conv_in), 32'd0);

    // release: first edge enters LOAD, slot 0 shows from the second edge
    @(negedge clk); rst_n = 1'b1; blank = 1'b0;
    @(negedge clk);
    chk("load_rdy", 32'(wr_ready), 32'd0);
    chk("load_an", 32'(an_o), 32'hFF);
    push_slot(0, 1);
    for (int s = 1; s < 8; s++) push_slot(s, DIV);
    push_slot(0, DIV);
    repeat (9) pop_check();

    // write -3 into val[1] during slot 0 HOLD
    wr_valid = 1'b1; wr_idx = 2'd1; wr_data = 4'hD; a0 = acc_cnt;
    #1 chk("hold_rdy", 32'(wr_ready), 32'd1);
    @(negedge clk); wr_valid = 1'b0;
    chk("wr1_acc", acc_cnt, a0 + 1);
    mval[1] = 4'hD; last_w = 1;
    push_slot(1, 0); push_slot(2, DIV); push_slot(3, DIV);
    repeat (3) pop_check();

    // hold a write across the slot 4 LOAD cycle
    n = 0;
    while (wr_ready !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("load_seen", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_idx = 2'd3; wr_data = 4'd5; a0 = acc_cnt;
    @(negedge clk);
    chk("load_noacc", acc_cnt, a0);
    chk("post_load_rdy", 32'(wr_ready), 32'd1);
    chk("slot4_an", 32'(an_o), 32'hEF);
    chk("slot4_seg", 32'(seg_o), 32'(exp_seg(4)));
    @(negedge clk); wr_valid = 1'b0;
    chk("acc_once", acc_cnt, a0 + 1);
    @(negedge clk);
    chk("acc_once_after", acc_cnt, a0 + 1);
    mval[3] = 4'd5; last_w = 3;
    push_slot(5, 0);
    pop_check();

    // blank during slot 5 HOLD, then resume at slot 5
    blank = 1'b1;
    @(negedge clk);
    chk("blank_an", 32'(an_o), 32'hFF);
    chk("blank_seg", 32'(seg_o), 32'hFF);
    chk("blank_rdy", 32'(wr_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("blank_hold_an", 32'(an_o), 32'hFF);
    blank = 1'b0;
    @(negedge clk);
    chk("resume_load", 32'(wr_ready), 32'd0);
    @(negedge clk);
    chk("resume_an", 32'(an_o), 32'hDF);
    chk("resume_seg", 32'(seg_o), 32'(exp_seg(5)));
    push_slot(6, DIV);
    pop_check();

    // async reset mid slot 6 HOLD with a write in flight
    @(negedge clk);
    chk("pre_rst_conv", 32'(conv_in), 32'd5);
    wr_valid = 1'b1; wr_idx = 2'd3; wr_data = 4'd7;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 32'(an_o), 32'hFF);
    chk("arst_seg", 32'(seg_o), 32'hFF);
    chk("arst_conv", 32'(conv_in), 32'd0);
    @(negedge clk); wr_valid = 1'b0;
    chk("arst_hold_an", 32'(an_o), 32'hFF);
    rst_n = 1'b1;
    foreach (mval[i]) mval[i] = 4'd0;
    last_w = 0;
    @(negedge clk);
    chk("rerun_load", 32'(wr_ready), 32'd0);
    push_slot(0, 1);
    for (int s = 1; s < 8; s++) push_slot(s, DIV);
    repeat (8) pop_check();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: clock cycles per display slot; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 blank  input  1  1 = all digits off, scan halted.
REQ-005 wr_valid  input  1  write request.
REQ-006 wr_ready  output  1  write accepted when wr_valid and wr_ready are both 1 on a rising edge.
REQ-007 wr_idx  input  2  value slot 0..3 being written.
REQ-008 wr_data  input  4  signed two's-complement value, -8..7.
REQ-009 conv_in  output  4  value presented to the shared bcd7segPro converter.
REQ-010 conv_out  input  16  converter result; [7:0] magnitude segments, [15:8] sign segments; active-low, bit0 = DP.
REQ-011 seg_o  output  8  segment drive for the enabled digit, active-low, bit0 = DP.
REQ-012 an_o  output  8  digit enables, active-low, one-hot-zero while scanning.

Function
REQ-013 Four 4-bit value registers val[0..3]; an accepted write stores wr_data into val[wr_idx] on that edge.
REQ-014 Eight display slots, slot[2:0]; slot s shows val[s>>1]; even s = magnitude digit (conv_out[7:0]), odd s = sign digit (conv_out[15:8]).
REQ-015 conv_in = val[slot>>1] combinationally at all times; the converter is treated as purely combinational.
REQ-016 FSM states IDLE, LOAD, HOLD.
REQ-017 IDLE: seg_o = 8'hFF, an_o = 8'hFF, wr_ready = 1; blank = 0 -> LOAD next edge, slot unchanged.
REQ-018 LOAD (exactly 1 cycle): wr_ready = 0; on exit edge seg_o <= selected half of conv_out, an_o <= ~(8'b1 << slot); cycle counter cleared; -> HOLD.
REQ-019 HOLD: wr_ready = 1; counter increments each cycle; at count DIV-2, next edge slot <= slot+1 (7 wraps to 0) and -> LOAD; seg_o/an_o held constant throughout HOLD.
REQ-020 Slot period = exactly DIV cycles (1 LOAD + DIV-1 HOLD); full frame = 8*DIV cycles.
REQ-021 seg_o/an_o change only on the LOAD exit edge or on entry to IDLE; no output glitch mid-slot.
REQ-022 Write to the value currently displayed during HOLD: val updates immediately, display shows the new value only at that slot's next LOAD.
REQ-023 Write presented during LOAD: not accepted; wr_valid held by the source is accepted on the following HOLD cycle.
REQ-024 blank = 1 in any state: -> IDLE next edge; seg_o/an_o = 8'hFF on that edge; val[] and slot retained.
REQ-025 wr_data = 4'b1000 (-8): stored and passed unchanged; displayed value is whatever the converter returns.

Reset
REQ-026 rst_n = 0 asynchronously forces: state IDLE, slot 0, counter 0, val[0..3] = 0, seg_o = 8'hFF, an_o = 8'hFF, last-write index 0.
REQ-027 Reset asserted mid-slot or mid-write aborts immediately; the in-flight write is not stored.
REQ-028 After rst_n release with blank = 0: first edge IDLE -> LOAD, slot 0 displayed from the second edge.

Configuration
REQ-029 Macro SEG_SCAN_DP_EN defined: a last-write index register records wr_idx of every accepted write; when a magnitude slot (even s) of val[last] is loaded, seg_o bit0 is forced 0 (DP lit).
REQ-030 SEG_SCAN_DP_EN undefined: no last-write register; seg_o bit0 always 1 (DP off) on every load; all other behaviour identical.

Verification
REQ-031 DIV=4, reset, blank=0, all val = 0 -> an_o steps FE,FD,FB,...,7F, each held 4 cycles, wraps to FE after 32 cycles.
REQ-032 Write idx=1 data=4'hD (-3) during HOLD -> slot 2 seg_o = converter pattern for 3, slot 3 seg_o = 8'b11111101.
REQ-033 wr_valid held high across a LOAD cycle -> wr_ready = 0 that cycle, write accepted exactly once on the next cycle.
REQ-034 blank = 1 in slot 5 HOLD -> next edge seg_o = an_o = FF; blank = 0 -> resumes LOAD at slot 5.
REQ-035 rst_n pulsed low mid-HOLD at slot 6 -> outputs FF asynchronously, val all 0, scan restarts at slot 0.
REQ-036 SEG_SCAN_DP_EN defined, write idx=2 -> slot 4 seg_o bit0 = 0, slots 0/2/6 bit0 = 1; undefined -> bit0 = 1 on all slots.
